// File: rtl/uart_program_loader_if.sv
// Instruction-memory write port driven by the UART program loader.
interface uart_program_loader_if #(
  parameter int ADDR_W = 8
);
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;

  modport master (output imem_we, imem_addr, imem_wdata);
  modport slave  (input  imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/uart_program_loader.sv
// Serial 8N1 program loader: count word, then N instruction words into imem from address 0.
// Optional trailing checksum word when LOADER_CHECKSUM_EN is defined.
module uart_program_loader #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int ADDR_W       = 8,
  parameter int MAX_INSTR    = 256
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  wait_transport,
  input  logic                  uart_rx_pin,
  uart_program_loader_if.master imem,
  output logic                  loading,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  frame_err,
  output logic                  chk_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [3:0] {
    L_IDLE, L_CNT_LO, L_CNT_HI, L_INS_LO, L_INS_HI, L_WR, L_DONE, L_CHK_LO, L_CHK_HI
  } ld_state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam ld_state_t L_AFTER_INS = L_CHK_LO;
`else
  localparam ld_state_t L_AFTER_INS = L_DONE;
`endif

  logic rx_s1, rx_s2, rx_prev;
  logic wt_s1, wt_s2, wt_prev;
  logic rx_fall, load_req;

  // Synchronisers start low so a line or button held low from reset never looks like an edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rx_s1   <= 1'b0;
      rx_s2   <= 1'b0;
      rx_prev <= 1'b0;
      wt_s1   <= 1'b0;
      wt_s2   <= 1'b0;
      wt_prev <= 1'b0;
    end else begin
      rx_s1   <= uart_rx_pin;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      wt_s1   <= wait_transport;
      wt_s2   <= wt_s1;
      wt_prev <= wt_s2;
    end
  end

  assign rx_fall  = rx_prev & ~rx_s2;
  assign load_req = wt_prev & ~wt_s2;

  rx_state_t       rx_state, rx_next;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      rx_byte;
  logic            half_tick, bit_tick;
  logic            byte_valid, stop_err;

  assign half_tick = (rx_cnt == CW'(CLKS_PER_BIT / 2 - 1));
  assign bit_tick  = (rx_cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next    = rx_state;
    byte_valid = 1'b0;
    stop_err   = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (half_tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_tick && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP: begin
        if (bit_tick) begin
          rx_next    = RX_IDLE;
          byte_valid = rx_s2;
          stop_err   = ~rx_s2;
        end
      end
      default:  rx_next = RX_IDLE;
    endcase
  end

  // The bit counter restarts at the mid-start sample so later samples land mid-bit.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rx_cnt  <= '0;
      bit_idx <= '0;
      rx_byte <= '0;
    end else begin
      if (rx_state == RX_IDLE || (rx_state == RX_START && half_tick) || bit_tick)
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + CW'(1);
      if (rx_state == RX_START)
        bit_idx <= '0;
      else if (rx_state == RX_DATA && bit_tick) begin
        rx_byte <= {rx_s2, rx_byte[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  ld_state_t         ld_state, ld_next;
  logic [7:0]        lo_q;
  logic [15:0]       count_q;
  logic [15:0]       wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       rx_word, count_clamped;
  logic              last_word;

  assign rx_word       = {rx_byte, lo_q};
  assign count_clamped = (rx_word > 16'(MAX_INSTR)) ? 16'(MAX_INSTR) : rx_word;
  assign last_word     = ((17'(addr_q) + 17'd1) == {1'b0, count_q});

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) ld_state <= L_IDLE;
    else        ld_state <= ld_next;
  end

  always_comb begin
    ld_next = ld_state;
    if (load_req) begin
      ld_next = L_CNT_LO;
    end else begin
      case (ld_state)
        L_CNT_LO: if (byte_valid) ld_next = L_CNT_HI;
        L_CNT_HI: if (byte_valid) ld_next = (count_clamped == 16'd0) ? L_AFTER_INS : L_INS_LO;
        L_INS_LO: if (byte_valid) ld_next = L_INS_HI;
        L_INS_HI: if (byte_valid) ld_next = L_WR;
        L_WR:     ld_next = last_word ? L_AFTER_INS : L_INS_LO;
        L_CHK_LO: if (byte_valid) ld_next = L_CHK_HI;
        L_CHK_HI: if (byte_valid) ld_next = L_DONE;
        L_DONE:   ld_next = L_IDLE;
        default:  ld_next = L_IDLE;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] sum_q;
  logic        chk_err_q;
`endif

  // A load request wins over any byte arriving in the same cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      lo_q      <= '0;
      count_q   <= '0;
      wdata_q   <= '0;
      addr_q    <= '0;
      frame_err <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q     <= '0;
      chk_err_q <= 1'b0;
`endif
    end else if (load_req) begin
      addr_q    <= '0;
      frame_err <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q     <= '0;
      chk_err_q <= 1'b0;
`endif
    end else begin
      if (stop_err)
        frame_err <= 1'b1;
      if (byte_valid) begin
        case (ld_state)
          L_CNT_LO, L_INS_LO, L_CHK_LO: lo_q <= rx_byte;
          L_CNT_HI: count_q <= count_clamped;
          L_INS_HI: wdata_q <= rx_word;
`ifdef LOADER_CHECKSUM_EN
          L_CHK_HI: if (rx_word != sum_q) chk_err_q <= 1'b1;
`endif
          default: ;
        endcase
      end
      if (ld_state == L_WR) begin
        addr_q <= addr_q + ADDR_W'(1);
`ifdef LOADER_CHECKSUM_EN
        sum_q  <= sum_q + wdata_q;
`endif
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

  assign imem.imem_we    = (ld_state == L_WR);
  assign imem.imem_addr  = addr_q;
  assign imem.imem_wdata = wdata_q;
  assign loading         = (ld_state != L_IDLE) && (ld_state != L_DONE);
  assign cpu_hold        = loading;
  assign load_done       = (ld_state == L_DONE);

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench for uart_program_loader: directed loads, expected writes and completions queued.
module tb_uart_program_loader;

  localparam int CPB       = 16;
  localparam int ADDR_W    = 8;
  localparam int MAX_INSTR = 256;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic wait_transport = 1'b1;
  logic uart_rx_pin = 1'b1;
  logic loading, cpu_hold, load_done, frame_err, chk_err;

  uart_program_loader_if #(.ADDR_W(ADDR_W)) imem_bus ();

  uart_program_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W(ADDR_W),
    .MAX_INSTR(MAX_INSTR)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .wait_transport(wait_transport),
    .uart_rx_pin(uart_rx_pin),
    .imem(imem_bus),
    .loading(loading),
    .cpu_hold(cpu_hold),
    .load_done(load_done),
    .frame_err(frame_err),
    .chk_err(chk_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_done;
    logic [7:0]  addr;
    logic [15:0] data;
    bit          exp_frame;
    bit          exp_chk;
    bit          after_we;
  } ev_t;

  ev_t         exp_q[$];
  logic [15:0] prog_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          last_we_cycle = 0;
  int          last_stop_cycle = 0;
  logic        prev_loading = 1'b0;
  ev_t         mon_ev;

  always @(posedge CLK) cycle++;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Monitor: every write strobe and completion pulse must match the head of the queue.
  always @(negedge CLK) begin
    if (RESET) begin
      if (imem_bus.imem_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_we addr=%0h data=%0h", imem_bus.imem_addr, imem_bus.imem_wdata);
        end else begin
          mon_ev = exp_q.pop_front();
          check_output("event_is_write", 32'd1, {31'd0, !mon_ev.is_done});
          check_output("imem_addr", {24'd0, imem_bus.imem_addr}, {24'd0, mon_ev.addr});
          check_output("imem_wdata", {16'd0, imem_bus.imem_wdata}, {16'd0, mon_ev.data});
        end
        last_we_cycle = cycle;
      end
      if (load_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_load_done actual=1 expected=0");
        end else begin
          mon_ev = exp_q.pop_front();
          check_output("event_is_done", 32'd1, {31'd0, mon_ev.is_done});
          check_output("done_frame_err", {31'd0, frame_err}, {31'd0, mon_ev.exp_frame});
          check_output("done_chk_err", {31'd0, chk_err}, {31'd0, mon_ev.exp_chk});
          check_output("done_loading_low", {31'd0, loading}, 32'd0);
          check_output("done_cpu_hold_low", {31'd0, cpu_hold}, 32'd0);
          check_output("loading_before_done", {31'd0, prev_loading}, 32'd1);
          if (mon_ev.after_we)
            check_output("done_after_we", cycle - last_we_cycle, 32'd1);
          else
            check_output("done_in_stop_bit",
                         {31'd0, (cycle > last_stop_cycle) && (cycle <= last_stop_cycle + CPB)}, 32'd1);
        end
      end
      prev_loading = loading;
    end
  end

  task automatic drive_bit(input logic b);
    uart_rx_pin = b;
    repeat (CPB) @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    last_stop_cycle = cycle;
    drive_bit(stop);
    drive_bit(1'b1);
  endtask

  task automatic request_load();
    @(posedge CLK);
    #1 wait_transport = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_output("loading_during_sync", {31'd0, loading}, 32'd0);
    @(posedge CLK);
    #1;
    check_output("loading_rise", {31'd0, loading}, 32'd1);
    check_output("cpu_hold_rise", {31'd0, cpu_hold}, 32'd1);
    check_output("req_clears_frame_err", {31'd0, frame_err}, 32'd0);
    check_output("req_clears_chk_err", {31'd0, chk_err}, 32'd0);
    check_output("req_clears_addr", {24'd0, imem_bus.imem_addr}, 32'd0);
    repeat (4) @(posedge CLK);
    #1 wait_transport = 1'b1;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 4 * CPB;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge CLK);
      budget--;
    end
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout pending=%0d expected=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // inject: 0 none, 1 byte with low stop bit, 2 short low glitch; both inserted after the count word.
  task automatic apply_stimulus(input logic [15:0] count_word, input logic [15:0] chk_delta, input int inject);
    ev_t         ev;
    logic [15:0] sum;
    int          n;
    sum = 16'd0;
    n = (int'(count_word) > MAX_INSTR) ? MAX_INSTR : int'(count_word);
    for (int i = 0; i < n; i++) begin
      ev.is_done   = 1'b0;
      ev.addr      = 8'(i);
      ev.data      = prog_q[i];
      ev.exp_frame = 1'b0;
      ev.exp_chk   = 1'b0;
      ev.after_we  = 1'b0;
      exp_q.push_back(ev);
      sum = sum + prog_q[i];
    end
    ev.is_done   = 1'b1;
    ev.addr      = 8'd0;
    ev.data      = 16'd0;
    ev.exp_frame = (inject == 1);
    ev.exp_chk   = CHK_ON && (chk_delta != 16'd0);
    ev.after_we  = (n > 0) && !CHK_ON;
    exp_q.push_back(ev);

    request_load();
    send_byte(count_word[7:0], 1'b1);
    send_byte(count_word[15:8], 1'b1);
    if (inject == 1) begin
      send_byte(8'h55, 1'b0);
    end else if (inject == 2) begin
      uart_rx_pin = 1'b0;
      repeat (CPB / 4) @(posedge CLK);
      #1 uart_rx_pin = 1'b1;
      repeat (2 * CPB) @(posedge CLK);
      #1;
    end
    for (int i = 0; i < n; i++) begin
      send_byte(prog_q[i][7:0], 1'b1);
      send_byte(prog_q[i][15:8], 1'b1);
    end
    if (CHK_ON) begin
      sum = sum + chk_delta;
      send_byte(sum[7:0], 1'b1);
      send_byte(sum[15:8], 1'b1);
    end
    wait_drain();
  endtask

  initial begin
    ev_t ev;
    $display("[TB] start");
    #1;
    check_output("rst_imem_we", {31'd0, imem_bus.imem_we}, 32'd0);
    check_output("rst_imem_addr", {24'd0, imem_bus.imem_addr}, 32'd0);
    check_output("rst_imem_wdata", {16'd0, imem_bus.imem_wdata}, 32'd0);
    check_output("rst_loading", {31'd0, loading}, 32'd0);
    check_output("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check_output("rst_load_done", {31'd0, load_done}, 32'd0);
    check_output("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check_output("rst_chk_err", {31'd0, chk_err}, 32'd0);
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b1;
    repeat (2 * CPB) @(posedge CLK);
    #1;

    $display("[TB] three-word program");
    prog_q = {16'h1234, 16'hABCD, 16'h0001};
    apply_stimulus(16'h0003, 16'd0, 0);

    $display("[TB] zero-length program");
    prog_q.delete();
    apply_stimulus(16'h0000, 16'd0, 0);

    $display("[TB] framing error mid-load");
    prog_q = {16'h5678};
    apply_stimulus(16'h0001, 16'd0, 1);
    check_output("frame_err_sticky", {31'd0, frame_err}, 32'd1);

    $display("[TB] glitch on idle line");
    prog_q = {16'hA55A};
    apply_stimulus(16'h0001, 16'd0, 2);

    $display("[TB] reset during instruction byte");
    ev.is_done = 1'b0; ev.addr = 8'd0; ev.data = 16'h2211;
    ev.exp_frame = 1'b0; ev.exp_chk = 1'b0; ev.after_we = 1'b0;
    exp_q.push_back(ev);
    request_load();
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    check_output("addr_before_reset", {24'd0, imem_bus.imem_addr}, 32'd1);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    RESET = 1'b0;
    #1;
    check_output("midrst_loading", {31'd0, loading}, 32'd0);
    check_output("midrst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check_output("midrst_imem_addr", {24'd0, imem_bus.imem_addr}, 32'd0);
    check_output("midrst_imem_wdata", {16'd0, imem_bus.imem_wdata}, 32'd0);
    check_output("midrst_imem_we", {31'd0, imem_bus.imem_we}, 32'd0);
    check_output("midrst_pending", exp_q.size(), 32'd0);
    repeat (3) @(posedge CLK);
    #1 uart_rx_pin = 1'b1;
    RESET = 1'b1;
    repeat (2 * CPB) @(posedge CLK);
    #1;
    prog_q = {16'hBEEF};
    apply_stimulus(16'h0001, 16'd0, 0);

`ifdef LOADER_CHECKSUM_EN
    $display("[TB] checksum good and bad");
    prog_q = {16'h0001, 16'h0002};
    apply_stimulus(16'h0002, 16'd0, 0);
    apply_stimulus(16'h0002, 16'd1, 0);
    repeat (4) @(posedge CLK);
    #1;
    check_output("chk_err_sticky", {31'd0, chk_err}, 32'd1);
`endif

    repeat (CPB) @(posedge CLK);
    #1;
    check_output("final_idle_loading", {31'd0, loading}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
